// File: rtl/fifo_upsize_pkg.sv
// Shared constants, count type and depth helper for the narrow-to-wide FIFO.
package fifo_upsize_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  // Count must reach DEPTH itself, hence one bit wider than the address.
  typedef logic [ADDR_WIDTH_DEF:0] count_t;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction
endpackage

// File: rtl/fifo_upsize_reg_file_pair.sv
// Storage array: one synchronous narrow write port, one combinational pair read port.
module reg_file_pair
  import fifo_upsize_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    w_en,
  input  logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [ADDR_WIDTH-1:0]   r_addr,
  output logic [2*DATA_WIDTH-1:0] r_data
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_lo;
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic                  unused_lsb;

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  // The pair always starts on an even address, so the LSB is forced here.
  assign addr_lo    = {r_addr[ADDR_WIDTH-1:1], 1'b0};
  assign addr_hi    = {r_addr[ADDR_WIDTH-1:1], 1'b1};
  assign unused_lsb = r_addr[0];
  assign r_data     = {mem[addr_lo], mem[addr_hi]};
endmodule

// File: rtl/fifo_upsize.sv
// Circular FIFO: one narrow word in per write, an older/newer pair out per read (fall-through).
// Optional sticky misuse flag err is compiled in with FIFO_UPSIZE_ERR_EN.
module fifo_upsize
  import fifo_upsize_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic                    rd,
  output logic [2*DATA_WIDTH-1:0] r_data,
  output logic                    empty,
  output logic                    one_held,
`ifdef FIFO_UPSIZE_ERR_EN
  output logic                    full,
  output logic                    err
`else
  output logic                    full
`endif
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  acc_wr;
  logic                  acc_rd;

  // Each request is judged only against the flags as they stand this cycle.
  assign acc_wr = wr & ~full;
  assign acc_rd = rd & ~empty & ~one_held;

  assign count_next = count
                    + {{ADDR_WIDTH{1'b0}}, acc_wr}
                    - {{(ADDR_WIDTH-1){1'b0}}, acc_rd, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      one_held <= 1'b0;
      full     <= 1'b0;
    end else begin
      if (acc_wr) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (acc_rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(2);
      count    <= count_next;
      empty    <= (count_next == '0);
      one_held <= (count_next == (ADDR_WIDTH+1)'(1));
      full     <= (count_next == DEPTH_C);
    end
  end

`ifdef FIFO_UPSIZE_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if ((wr & full) | (rd & (empty | one_held))) err <= 1'b1;
  end
`endif

  reg_file_pair #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .w_en   (acc_wr),
    .w_addr (wr_ptr),
    .w_data (w_data),
    .r_addr (rd_ptr),
    .r_data (r_data)
  );
endmodule

// File: doc/fifo_upsize.md
# fifo_upsize

Circular-queue FIFO that accepts one DATA_WIDTH word per write and returns two words, packed as one 2*DATA_WIDTH word, per read. It is the narrow-to-wide companion of the team's wide-write/narrow-read FIFO controller. It sits between byte-serial producers and word-wide consumers. It contains the storage array and the pointer/flag controller.

## Interface
- DATA_WIDTH, 8, width of one written word
- ADDR_WIDTH, 4, address bits; depth DEPTH = 2**ADDR_WIDTH words (even)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- wr  input  1  write request, one word
- w_data  input  DATA_WIDTH  write data
- rd  input  1  read request, one pair
- r_data  output  2*DATA_WIDTH  {older word, newer word} at head
- empty  output  1  zero words held
- one_held  output  1  exactly one word held; a pair is not yet available
- full  output  1  DEPTH words held
- err  output  1  sticky misuse flag; present only with FIFO_UPSIZE_ERR_EN

## Operation
- State:
  - wr_ptr, ADDR_WIDTH bits, +1 per accepted write.
  - rd_ptr, ADDR_WIDTH bits, +2 per accepted read.
  - count, ADDR_WIDTH+1 bits, range 0..DEPTH.
  - Registered flags empty, one_held and full.
- rd_ptr is always even, so a pair never straddles the wrap point.
- Pair addresses: rd_ptr and rd_ptr+1, which is rd_ptr with its LSB set.
- r_data[2*DATA_WIDTH-1:DATA_WIDTH] = mem[rd_ptr], the first-written word. r_data[DATA_WIDTH-1:0] = mem[rd_ptr+1].
- Write is accepted iff wr & ~full. mem[wr_ptr] <= w_data; wr_ptr wraps modulo DEPTH.
- Read is accepted iff rd & ~empty & ~one_held, i.e. count >= 2. rd_ptr wraps from DEPTH-2 to 0.
- Both rd and wr asserted: each request is judged only against the current flags.
  - Full: the read is accepted, the write is dropped, and count decreases by 2.
  - count = 1: the write is accepted, the read is dropped, and count becomes 2.
  - count from 2 to DEPTH-1: both are accepted, and count decreases by 1.
- Next count = count + acc_wr - 2*acc_rd.
- Flags are loaded from next count: empty = (next count == 0), one_held = (next count == 1), full = (next count == DEPTH).
- A rejected request changes no state except err, when err is compiled in.

## Timing
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, one_held = 0, full = 0, err = 0.
- Memory contents are not reset. r_data is undefined while count < 2.
- Writes commit at the rising edge. Flags and pointers update at the same edge.
- r_data is a combinational read of mem at rd_ptr (first-word fall-through).
- r_data is valid in the cycle where count >= 2. A read accepted at edge N shows the next pair after edge N.
- Write-to-read latency is one cycle: the edge that writes the second word of a pair makes that pair visible.
- Reset asserted mid-operation discards all contents in one cycle. Requests in the reset cycle are ignored.

## Configuration
- FIFO_UPSIZE_ERR_EN defined:
  - Port err exists.
  - err is set at the edge after a dropped request: wr while full, or rd while count < 2.
  - Both-asserted cases count only the dropped half.
  - err holds until reset.
- FIFO_UPSIZE_ERR_EN undefined: there is no err port and no error logic. All other behaviour is identical.

## Structure
- Package fifo_upsize_pkg holds:
  - Default DATA_WIDTH and ADDR_WIDTH constants.
  - typedef for the count width.
  - Helper function returning DEPTH from ADDR_WIDTH.
- Sub-module reg_file_pair: one synchronous write port, one combinational pair-read port.
  - Inputs: w_en, w_addr, w_data, r_addr. The LSB of r_addr is ignored.
  - Output: packed pair.
- The top level holds pointers, count, flags and err, and instantiates reg_file_pair.

## Test plan
- Reset, then idle: empty=1, one_held=0, full=0, err=0 on the cycle after reset.
- Write 8'hA1, then rd=1 alone: one_held=1 and count stays 1, with err=1 if enabled. Write 8'hB2: r_data=16'hA1B2. Assert rd: empty=1.
- Write 8'h00..8'h0F, then write 8'hFF: full=1 after the 16th write and 8'hFF is dropped. Eight reads return 16'h0001, 16'h0203, …, 16'h0E0F, then empty=1.
- Wrap-around:
  - Write 14 words, read 7 pairs, write 8'h20..8'h23.
  - Read 16'h2021: rd_ptr goes 14 to 0.
  - Read 16'h2223.
- Simultaneous:
  - At full, rd=wr=1: count becomes 14 and full=0.
  - At count=1, rd=wr=1 with 8'h55: count=2, pair = {prior word, 8'h55}.
  - At count=5, rd=wr=1: count becomes 4.
- Reset asserted while count=9: the next cycle shows empty=1, full=0, one_held=0. A new write of 8'h77 then 8'h88 yields r_data=16'h7788.
